// File: rtl/ee357_mult_seq_pkg.sv
// Shared constants and state encoding for the
// MULT/MULTU sequencer and its ALU neighbours.
package ee357_mult_seq_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = 5;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIXA,
    ST_FIXB,
    ST_DONE
  } mult_state_e;

  typedef struct packed {
    logic sa;
    logic sb;
  } mult_sign_t;

  function automatic mult_sign_t
    sign_capture(input logic sgn,
                 input logic msb_a,
                 input logic msb_b);
    mult_sign_t s;
    s.sa = sgn & msb_a;
    s.sb = sgn & msb_b;
    return s;
  endfunction

endpackage

// File: rtl/ee357_mult_seq.sv
// Multicycle MULT/MULTU sequencer: drives the shared
// ALU through shift-add iterations plus signed fixups.
module ee357_mult_seq
  import ee357_mult_seq_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mult_start,
  input  logic             mult_signed,
  input  logic [WIDTH-1:0] mult_opa,
  input  logic [WIDTH-1:0] mult_opb,
  output logic             mult_busy,
  output logic             mult_done,
  output logic [WIDTH-1:0] mult_hi,
  output logic [WIDTH-1:0] mult_lo,
  output logic [WIDTH-1:0] alu_opa,
  output logic [WIDTH-1:0] alu_opb,
  output logic [5:0]       alu_func,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_cout
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(WIDTH - 1);

  mult_state_e      state;
  mult_state_e      state_nx;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;
  mult_sign_t       sgn;
  mult_sign_t       sgn_in;

  assign sgn_in = sign_capture(mult_signed,
                               mult_opa[WIDTH-1],
                               mult_opb[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // IDLE and DONE leave the ALU on ADD 0+0
  always_comb begin
    state_nx = state;
    alu_func = FUNC_ADD;
    alu_opa  = '0;
    alu_opb  = '0;
    unique case (state)
      ST_IDLE: begin
        if (mult_start) state_nx = ST_RUN;
      end
      ST_RUN: begin
        alu_opa = hi;
        alu_opb = lo[0] ? mcand : '0;
        if (cnt == CNT_LAST) begin
          state_nx = (sgn.sa | sgn.sb) ?
                     ST_FIXA : ST_DONE;
        end
      end
      ST_FIXA: begin
        alu_func = FUNC_SUB;
        alu_opa  = hi;
        alu_opb  = sgn.sa ? mplier : '0;
        state_nx = ST_FIXB;
      end
      ST_FIXB: begin
        alu_func = FUNC_SUB;
        alu_opa  = hi;
        alu_opb  = sgn.sb ? mcand : '0;
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      sgn    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (mult_start) begin
            mcand  <= mult_opa;
            mplier <= mult_opb;
            hi     <= '0;
            lo     <= mult_opb;
            cnt    <= '0;
            sgn    <= sgn_in;
          end
        end
        ST_RUN: begin
          // ADD carry becomes the new hi MSB
          {hi, lo} <= {alu_cout, alu_res,
                       lo[WIDTH-1:1]};
          cnt      <= cnt + 1'b1;
        end
        ST_FIXA, ST_FIXB: begin
          hi <= alu_res;
        end
        default: begin
        end
      endcase
    end
  end

  assign mult_busy = (state == ST_RUN)  ||
                     (state == ST_FIXA) ||
                     (state == ST_FIXB);
  assign mult_done = (state == ST_DONE);
  assign mult_hi   = hi;
  assign mult_lo   = lo;

endmodule
